// File: rtl/apb_timer_slave.sv
// apb_timer_slave: zero-wait-state APB slave wrapping a prescaled down-counter
// with auto-reload, W1C status flags and a level interrupt.
module apb_timer_slave (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Irq
);

  typedef enum logic [2:0] {
    A_CTRL    = 3'd0,
    A_LOAD    = 3'd1,
    A_COUNT   = 3'd2,
    A_STATUS  = 3'd3,
    A_SCRATCH = 3'd4
  } reg_addr_e;

  // Register state
  logic        en_q,       en_d;
  logic        auto_q,     auto_d;
  logic        irq_en_q,   irq_en_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [31:0] load_q,     load_d;
  logic [31:0] count_q,    count_d;
  logic        expired_q,  expired_d;
  logic        overrun_q,  overrun_d;
  logic [31:0] scratch_q,  scratch_d;
  logic [7:0]  pre_cnt_q,  pre_cnt_d;
  logic [31:0] prdata_q,   prdata_d;

  // Decode and event strobes
  logic [2:0]  addr;
  logic        wr_en, rd_cap;
  logic        wr_ctrl, wr_load, wr_status, wr_scratch;
  logic        en_rise, en_clear_wr;
  logic        tick, tick_eff, expire;
  logic        clr_exp, clr_ovr;
  logic [31:0] rdata;
  logic        unused_addr;

  assign addr        = Paddr[4:2];
  assign unused_addr = ^{Paddr[31:5], Paddr[1:0]};

  assign wr_en  = Psel & Penable & Pwrite;
  assign rd_cap = Psel & ~Penable & ~Pwrite;

  assign wr_ctrl    = wr_en && (addr == A_CTRL);
  assign wr_load    = wr_en && (addr == A_LOAD);
  assign wr_status  = wr_en && (addr == A_STATUS);
  assign wr_scratch = wr_en && (addr == A_SCRATCH);

  assign en_rise     = wr_ctrl &&  Pwdata[0] && !en_q;
  assign en_clear_wr = wr_ctrl && !Pwdata[0];

  // A LOAD write or an EN-clearing CTRL write in the same cycle swallows the tick.
  assign tick     = en_q && (pre_cnt_q == prescale_q);
  assign tick_eff = tick && !en_clear_wr && !wr_load;
  assign expire   = tick_eff && (count_q == '0);

  assign clr_exp = wr_status && Pwdata[0];
  assign clr_ovr = wr_status && Pwdata[1];

  // Read mux over pre-edge register values
  always_comb begin
    rdata = '0;
    case (addr)
      A_CTRL:    rdata = {16'h0000, prescale_q, 5'b00000, irq_en_q, auto_q, en_q};
      A_LOAD:    rdata = load_q;
      A_COUNT:   rdata = count_q;
      A_STATUS:  rdata = {30'h0, overrun_q, expired_q};
      A_SCRATCH: rdata = scratch_q;
      default:   rdata = '0;
    endcase
  end

  // Control register: APB writes, then expire without AUTO stops the timer
  always_comb begin
    en_d       = en_q;
    auto_d     = auto_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    if (wr_ctrl) begin
      en_d       = Pwdata[0];
      auto_d     = Pwdata[1];
      irq_en_d   = Pwdata[2];
      prescale_d = Pwdata[15:8];
    end
    if (expire && !auto_q) begin
      en_d = 1'b0;
    end
  end

  // Prescaler: held at 0 while disabled, restarted on enable and on every tick
  always_comb begin
    if (!en_d || en_rise || tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + 8'd1;
    end
  end

  // LOAD/COUNT: a LOAD write also seeds COUNT and beats any tick that cycle
  always_comb begin
    load_d  = wr_load ? Pwdata : load_q;
    count_d = count_q;
    if (wr_load) begin
      count_d = Pwdata;
    end else if (tick_eff) begin
      if (count_q != '0) begin
        count_d = count_q - 32'd1;
      end else if (auto_q) begin
        count_d = load_q;
      end
    end
  end

  // Status flags: expire set beats a simultaneous W1C clear
  always_comb begin
    expired_d = expired_q;
    overrun_d = overrun_q;
    if (clr_exp) begin
      expired_d = 1'b0;
    end
    if (clr_ovr) begin
      overrun_d = 1'b0;
    end
    if (expire) begin
      expired_d = 1'b1;
      if (expired_q && !clr_exp) begin
        overrun_d = 1'b1;
      end
    end
  end

  // Scratch register and read-data capture in the setup phase
  always_comb begin
    scratch_d = wr_scratch ? Pwdata : scratch_q;
    prdata_d  = rd_cap ? rdata : prdata_q;
  end

  // State register with synchronous reset taking priority over everything
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      load_q     <= '0;
      count_q    <= '0;
      expired_q  <= 1'b0;
      overrun_q  <= 1'b0;
      scratch_q  <= '0;
      pre_cnt_q  <= '0;
      prdata_q   <= '0;
    end else begin
      en_q       <= en_d;
      auto_q     <= auto_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      load_q     <= load_d;
      count_q    <= count_d;
      expired_q  <= expired_d;
      overrun_q  <= overrun_d;
      scratch_q  <= scratch_d;
      pre_cnt_q  <= pre_cnt_d;
      prdata_q   <= prdata_d;
    end
  end

  assign Prdata = prdata_q;
  assign Irq    = expired_q & irq_en_q;

endmodule
